// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if
//   Request/response bundle for the multi-cycle shift sequencer.
//   Parameter WIDTH sets the operand width; the shift-amount width is derived
//   as $clog2(WIDTH).
//   Request side : req_valid, req_ready, req_data, req_amt, req_mode
//   Response side: resp_valid, resp_ready, resp_data
//   Status       : busy
//   modport master : the ALU issue logic (drives requests, accepts results)
//   modport slave  : the sequencer itself
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  localparam int AMT_W = $clog2(WIDTH);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [AMT_W-1:0] req_amt;
  logic [1:0]       req_mode;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             busy;

  modport master (
    output req_valid, req_data, req_amt, req_mode, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_mode, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Multi-cycle shift sequencer (SLL / SRA / ROR) replacing a single-cycle
//   barrel shifter. One radix-2 stage (2^(AMT_W-1) down to 1) is applied per
//   clock to an internal accumulator; the result is presented with a
//   valid/ready handshake.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - synchronous, active-low reset
//     bus    - shift_seq_ctrl_if.slave (request, response and busy signals)
//   req_mode: 00 SLL, 01 SRA, 10 ROR, 11 pass-through.
//   Optional feature macro: SHIFT_SEQ_EARLY_EXIT_EN
//     defined   - stages whose amount bit is zero are skipped, amount 0 goes
//                 straight to DONE (latency 1 + popcount(amt)).
//     undefined - always AMT_W shift cycles (latency AMT_W + 1).
//   Results are identical in both builds.
module shift_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  shift_seq_ctrl_if.slave bus
);
  localparam int AMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [AMT_W-1:0] stage_q, stage_d;
  logic [1:0]       mode_q, mode_d;

  logic [AMT_W-1:0] shamt;
  logic [WIDTH-1:0] stage_res;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  logic [AMT_W-1:0] lower_bits;

  // Index of the most significant set bit; callers guarantee v != 0.
  function automatic logic [AMT_W-1:0] msb_index(input logic [AMT_W-1:0] v);
    logic [AMT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < AMT_W; i++) begin
      if (v[i]) idx = AMT_W'(i);
    end
    return idx;
  endfunction

  // Amount bits strictly below the current stage: the remaining work.
  assign lower_bits = amt_q & ((AMT_W'(1) << stage_q) - AMT_W'(1));
`endif

  // One radix-2 stage: shift the accumulator by 2^stage according to mode.
  // The rotate amount is never zero, so WIDTH - shamt stays below WIDTH.
  always_comb begin
    shamt = AMT_W'(1) << stage_q;
    case (mode_q)
      2'b00:   stage_res = acc_q << shamt;
      2'b01:   stage_res = $unsigned($signed(acc_q) >>> shamt);
      2'b10:   stage_res = (acc_q >> shamt) | (acc_q << (WIDTH - int'(shamt)));
      default: stage_res = acc_q;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    mode_d  = mode_q;
    stage_d = stage_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          acc_d  = bus.req_data;
          amt_d  = bus.req_amt;
          mode_d = bus.req_mode;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
          if (bus.req_amt == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
            stage_d = msb_index(bus.req_amt);
          end
`else
          state_d = SHIFT;
          stage_d = AMT_W'(AMT_W - 1);
`endif
        end
      end
      SHIFT: begin
        if (amt_q[stage_q]) acc_d = stage_res;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        if (lower_bits == '0) begin
          state_d = DONE;
        end else begin
          stage_d = msb_index(lower_bits);
        end
`else
        if (stage_q == '0) begin
          state_d = DONE;
        end else begin
          stage_d = stage_q - AMT_W'(1);
        end
`endif
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      stage_q <= stage_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_data  = acc_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl
//   Self-checking bench for shift_seq_ctrl: directed cases, backpressure,
//   mid-operation reset, and randomized back-to-back operations compared
//   against a whole-amount reference model. Inputs change and outputs are
//   observed on the falling clock edge.
module tb_shift_seq_ctrl;
  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  shift_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Whole-amount reference: the result of shifting by amt in one step.
  function automatic logic [15:0] refShift(input logic [1:0] mode,
                                           input logic [15:0] d, input int amt);
    logic [31:0] dd;
    case (mode)
      2'b00:   return d << amt;
      2'b01:   return 16'($signed(d) >>> amt);
      2'b10:   begin dd = {d, d}; return dd[amt +: 16]; end
      default: return d;
    endcase
  endfunction

  // Cycle (counting the accept cycle as 0) in which resp_valid first rises.
  function automatic int refLatency(input int amt);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    return 1 + $countones(amt);
`else
    return AMT_W + 1;
`endif
  endfunction

  // Issue one operation, follow it to completion with optional backpressure,
  // keeping req_valid asserted (with junk payload) while the block is busy.
  task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] data,
                               input int amt, input logic [15:0] expected,
                               input int holdCycles);
    int cyc;
    bit got;
    @(negedge clk);
    checkOutput("idle_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_data   = data;
    bus.req_amt    = 4'(amt);
    bus.req_mode   = mode;
    bus.resp_ready = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      bus.req_data = 16'($urandom);
      bus.req_amt  = 4'($urandom);
      bus.req_mode = 2'($urandom);
      if (bus.resp_valid) begin
        got = 1'b1;
      end else begin
        checkOutput("busy_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("busy_flag", 32'(bus.busy), 32'd1);
      end
    end
    checkOutput("latency", 32'(cyc), 32'(refLatency(amt)));
    checkOutput("result", 32'(bus.resp_data), 32'(expected));
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
      checkOutput("hold_resp_data", 32'(bus.resp_data), 32'(expected));
      checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("hold_busy", 32'(bus.busy), 32'd1);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("post_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("post_busy", 32'(bus.busy), 32'd0);
    checkOutput("post_resp_data", 32'(bus.resp_data), 32'(expected));
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    logic [1:0]  m;
    logic [15:0] d;
    int          a;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_data   = '0;
    bus.req_amt    = '0;
    bus.req_mode   = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset_resp_data", 32'(bus.resp_data), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);

    $display("[TB] directed operations");
    applyStimulus(2'b01, 16'h8000, 4,  16'hF800, 0);
    applyStimulus(2'b00, 16'h0001, 15, 16'h8000, 0);
    applyStimulus(2'b10, 16'h1234, 4,  16'h4123, 0);
    applyStimulus(2'b11, 16'hBEEF, 7,  16'hBEEF, 0);
    applyStimulus(2'b00, 16'hA5A5, 0,  16'hA5A5, 0);
    applyStimulus(2'b10, 16'h0001, 1,  16'h8000, 3);

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    $display("[TB] early-exit operations");
    applyStimulus(2'b01, 16'h8000, 10, 16'hFFE0, 0);
    applyStimulus(2'b10, 16'h1234, 0,  16'h1234, 1);
`endif

    $display("[TB] reset during shift");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_data  = 16'hFFFF;
    bus.req_amt   = 4'd3;
    bus.req_mode  = 2'b00;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("abort_resp_data", 32'(bus.resp_data), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    applyStimulus(2'b01, 16'h7FFF, 1, 16'h3FFF, 0);

    $display("[TB] random back-to-back operations");
    for (int n = 0; n < 1000; n++) begin
      m = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      a = int'($urandom_range(0, 15));
      applyStimulus(m, d, a, refShift(m, d, a), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
